branch_resolve_bht: RTL and testbench



---
 rtl/branch_resolve_bht_pkg.sv | 50 +++++
 rtl/branch_resolve_bht_sat_counter32.sv | 22 ++
 rtl/branch_resolve_bht.sv | 131 +++++++++++++
 tb/tb_branch_resolve_bht.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_bht_pkg.sv
// branch_resolve_bht_pkg: resolve/prediction bundles and BHT sweep types.
// Shared by the frontend BHT and its perf counter slice.
package branch_resolve_bht_pkg;

  localparam int unsigned VLEN = 64;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
    logic            is_mispredict;
    logic            is_taken;
    cf_t             cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef enum logic {
    BHT_IDLE,
    BHT_CLEAR
  } bht_clr_state_e;

  localparam logic [1:0] BHT_CNT_INIT = 2'b01;

  function automatic logic [1:0] bht_cnt_step(
    input logic [1:0] cnt,
    input logic       up
  );
    logic [1:0] nxt;
    nxt = cnt;
    if (up) begin
      if (cnt != 2'b11) nxt = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_sat_counter32.sv
// sat_counter32: 32-bit event counter that sticks at all-ones.
// Cleared only by the asynchronous reset.
module sat_counter32 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: 2-bit counter BHT trained by resolved branches, with sweep clear.
// Optional perf counters under BHT_PERF_CNT_EN.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  input  bp_resolve_t     resolved_branch_i,
  output bht_prediction_t bht_prediction_o,
  output logic            ready_o,
  output logic [31:0]     perf_updates_o,
  output logic [31:0]     perf_mispredicts_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  bht_clr_state_e   state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  logic [NR_ENTRIES-1:0] valid_q;
  logic [1:0]            cnt_q [NR_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_ok;
  logic             upd_we;
  logic             clr_we;
  logic [1:0]       cnt_nxt;

  assign rd_idx  = vpc_i[IDX_W:1];
  assign upd_idx = resolved_branch_i.pc[IDX_W:1];

  assign ready_o = (state_q == BHT_IDLE);
  assign clr_we  = (state_q == BHT_CLEAR);

  assign upd_ok = resolved_branch_i.valid
                & (resolved_branch_i.cf_type == Branch)
                & ~debug_mode_i
                & ready_o;
  // A flush in the same cycle takes priority over training.
  assign upd_we = upd_ok & ~flush_i;

  assign cnt_nxt = bht_cnt_step(cnt_q[upd_idx],
                                resolved_branch_i.is_taken);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      BHT_IDLE: begin
        if (flush_i) begin
          state_d   = BHT_CLEAR;
          clr_idx_d = '0;
        end
      end
      BHT_CLEAR: begin
        if (flush_i) begin
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
          if (&clr_idx_q) state_d = BHT_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= BHT_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clr_we) begin
      valid_q[clr_idx_q] <= 1'b0;
    end else if (upd_we) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Counter storage has no reset; the sweep initialises it.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      cnt_q[clr_idx_q] <= BHT_CNT_INIT;
    end else if (upd_we) begin
      cnt_q[upd_idx] <= cnt_nxt;
    end
  end

  assign bht_prediction_o.valid = ready_o & valid_q[rd_idx];
  assign bht_prediction_o.taken = ready_o & cnt_q[rd_idx][1];

`ifdef BHT_PERF_CNT_EN
  sat_counter32 u_perf_upd (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (upd_we),
    .cnt_o  (perf_updates_o)
  );

  sat_counter32 u_perf_mis (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (upd_we & resolved_branch_i.is_mispredict),
    .cnt_o  (perf_mispredicts_o)
  );
`else
  assign perf_updates_o     = '0;
  assign perf_mispredicts_o = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{resolved_branch_i.target_address,
                         resolved_branch_i.is_mispredict,
                         resolved_branch_i.pc[VLEN-1:IDX_W+1],
                         resolved_branch_i.pc[0],
                         vpc_i[VLEN-1:IDX_W+1],
                         vpc_i[0]};

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb_branch_resolve_bht: directed scoreboard bench for branch_resolve_bht.
// Define BHT_PERF_CNT_EN to also exercise the perf counters.
module tb_branch_resolve_bht;
  import branch_resolve_bht_pkg::*;

  localparam logic [63:0] PC_A = 64'h8000_0010;
  localparam logic [63:0] PC_B = 64'h8000_0100;
  localparam logic [63:0] PC_C = 64'h8000_0012;
  localparam logic [63:0] PC_D = 64'h8000_0011;
  localparam logic [63:0] PC_E = 64'h8000_0810;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            debug_mode_i = 1'b0;
  logic [63:0]     vpc_i = '0;
  bp_resolve_t     rb = '0;
  bht_prediction_t pred;
  logic            ready_o;
  logic [31:0]     perf_upd;
  logic [31:0]     perf_mis;

  int n_cmp = 0;
  int n_err = 0;
  int lo;
  bit seen_v;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  branch_resolve_bht dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .debug_mode_i       (debug_mode_i),
    .vpc_i              (vpc_i),
    .resolved_branch_i  (rb),
    .bht_prediction_o   (pred),
    .ready_o            (ready_o),
    .perf_updates_o     (perf_upd),
    .perf_mispredicts_o (perf_mis)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [63:0] pc, input cf_t cf,
                     input logic tk, input logic mp, input logic dbg);
    rb.valid          = v;
    rb.pc             = pc;
    rb.target_address = pc + 64'd64;
    rb.cf_type        = cf;
    rb.is_taken       = tk;
    rb.is_mispredict  = mp;
    debug_mode_i      = dbg;
  endtask

  task automatic idle_in();
    rb.valid     = 1'b0;
    debug_mode_i = 1'b0;
    flush_i      = 1'b0;
  endtask

  task automatic pred_at(input string tag, input logic [63:0] pc,
                         input logic [1:0] e);
    vpc_i = pc;
    exp_q.push_back(e);
    @(negedge clk);
    chk(tag, {62'd0, pred.valid, pred.taken}, {62'd0, exp_q.pop_front()});
  endtask

  task automatic wait_ready(input string tag, input int exp_cyc);
    int i;
    bit sv;
    sv = 1'b0;
    for (i = 0; i < exp_cyc + 64; i++) begin
      if (ready_o) break;
      if (pred.valid) sv = 1'b1;
      nxt();
    end
    chk({tag, "_rise"}, i, exp_cyc);
    chk({tag, "_pvalid"}, sv, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst_ni = 1'b0;
    vpc_i  = PC_A;
    repeat (2) nxt();
    chk("rst_ready", ready_o, 1'b0);
    pred_at("rst_pred", PC_A, 2'b00);
    chk("rst_perf_upd", perf_upd, 32'd0);
    nxt();
    rst_ni = 1'b1;
    wait_ready("sweep0", 1024);
    pred_at("post_sweep_a", PC_A, 2'b00);
    pred_at("post_sweep_b", PC_B, 2'b00);

    nxt(); drv(1, PC_A, Branch, 1, 0, 0); pred_at("tk1", PC_A, 2'b00);
    nxt(); drv(1, PC_A, Branch, 1, 1, 0); pred_at("tk2_pre", PC_A, 2'b11);
    nxt(); idle_in();                    pred_at("tk2_post", PC_A, 2'b11);
    for (int k = 0; k < 4; k++) begin
      nxt(); drv(1, PC_A, Branch, 0, 0, 0);
      pred_at("nt", PC_A, (k < 2) ? 2'b11 : 2'b10);
    end
    nxt(); drv(1, PC_A, Branch, 0, 0, 0); pred_at("nt_sat", PC_A, 2'b10);
    nxt(); drv(1, PC_A, Branch, 1, 0, 0); pred_at("sat_probe_pre", PC_A, 2'b10);
    nxt(); idle_in();                    pred_at("sat_probe", PC_A, 2'b10);

    nxt(); drv(1, PC_A, JumpR,  1, 0, 0); pred_at("jr_a", PC_A, 2'b10);
    nxt(); drv(1, PC_B, JumpR,  1, 0, 0); pred_at("jr_b", PC_B, 2'b00);
    nxt(); drv(1, PC_A, Return, 1, 0, 0); pred_at("ret_a", PC_A, 2'b10);
    nxt(); drv(1, PC_B, Jump,   1, 0, 0); pred_at("jal_b", PC_B, 2'b00);
    nxt(); drv(1, PC_A, Branch, 1, 0, 1); pred_at("dbg_a", PC_A, 2'b10);
    nxt(); drv(1, PC_B, Branch, 1, 0, 1); pred_at("dbg_b", PC_B, 2'b00);
    nxt(); drv(0, PC_B, Branch, 1, 0, 0); pred_at("nv_b", PC_B, 2'b00);
    nxt(); idle_in();
    pred_at("ign_a", PC_A, 2'b10);
    pred_at("ign_b", PC_B, 2'b00);
    pred_at("idx_bit0", PC_D, 2'b10);
    pred_at("idx_c16", PC_C, 2'b00);
    pred_at("idx_alias", PC_E, 2'b10);
`ifdef BHT_PERF_CNT_EN
    chk("perf_upd_train", perf_upd, 32'd8);
    chk("perf_mis_train", perf_mis, 32'd1);
`else
    chk("perf_upd_off", perf_upd, 32'd0);
    chk("perf_mis_off", perf_mis, 32'd0);
`endif

    nxt(); flush_i = 1'b1; drv(1, PC_B, Branch, 1, 1, 0);
    pred_at("fl_same", PC_B, 2'b00);
    nxt();
    seen_v = 1'b0;
    for (lo = 0; lo < 4000; lo++) begin
      if (ready_o) break;
      if (pred.valid) seen_v = 1'b1;
      flush_i = (lo == 499);
      drv(1, PC_A, Branch, 1, 0, 0);
      nxt();
    end
    idle_in();
    chk("flush_low", lo, 1524);
    chk("flush_pvalid", seen_v, 1'b0);
    pred_at("fl_a", PC_A, 2'b00);
    pred_at("fl_b", PC_B, 2'b00);
    pred_at("fl_e", PC_E, 2'b00);
`ifdef BHT_PERF_CNT_EN
    chk("perf_upd_flush", perf_upd, 32'd8);
    chk("perf_mis_flush", perf_mis, 32'd1);
`endif

    nxt(); drv(1, PC_A, Branch, 1, 0, 0);
    nxt(); drv(1, PC_A, Branch, 1, 0, 0);
    nxt(); idle_in(); pred_at("pre_rst", PC_A, 2'b11);
    nxt(); flush_i = 1'b1;
    nxt(); flush_i = 1'b0;
    repeat (300) nxt();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_mid_ready", ready_o, 1'b0);
    pred_at("rst_mid_pred", PC_A, 2'b00);
    chk("rst_mid_perf", perf_upd, 32'd0);
    nxt();
    rst_ni = 1'b1;
    wait_ready("sweep_rst", 1024);
    pred_at("post_rst_a", PC_A, 2'b00);

    nxt(); drv(1, PC_A, Branch, 1, 0, 0);
    nxt(); drv(1, PC_B, Branch, 1, 1, 0);
    nxt(); drv(1, PC_A, JumpR,  1, 1, 0);
    nxt(); drv(1, PC_A, Branch, 0, 0, 0);
    nxt(); idle_in(); pred_at("perf_seq_b", PC_B, 2'b11);
`ifdef BHT_PERF_CNT_EN
    chk("perf_upd3", perf_upd, 32'd3);
    chk("perf_mis1", perf_mis, 32'd1);
    nxt();
    force dut.u_perf_upd.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf_upd.cnt_q;
    nxt(); drv(1, PC_A, Branch, 1, 0, 0);
    nxt(); idle_in();
    chk("perf_sat", perf_upd, 32'hFFFF_FFFF);
    chk("perf_mis_keep", perf_mis, 32'd1);
`else
    chk("perf_upd_off2", perf_upd, 32'd0);
    chk("perf_mis_off2", perf_mis, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
